// File: rtl/shifter_pkg.sv
// Shared op encoding for the pipelined barrel shifter and its stages.
// No logic here; latency and backpressure are owned by the users of the package.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } op_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by DIST, then a register; 1 cycle.
// Loads only when adv is high, otherwise every register holds its value.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int SHW   = 5,
  parameter int DIST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  input  logic [SHW-1:0]   in_sha,
  input  op_t              in_op,
  input  logic             in_sgn,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic [SHW-1:0]   out_sha,
  output op_t              out_op,
  output logic             out_sgn,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEL = $clog2(DIST);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [SHW-1:0]   sha_q, sha_d;
  op_t              op_q,  op_d;
  logic             sgn_q, sgn_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] shifted;

  // SRA fills from the operand's original MSB, carried alongside the op.
  always_comb begin
    shifted = in_dat;
    if (in_sha[SEL]) begin
      case (in_op)
        OP_SRL:  shifted = {{DIST{1'b0}}, in_dat[WIDTH-1:DIST]};
        OP_SRA:  shifted = {{DIST{in_sgn}}, in_dat[WIDTH-1:DIST]};
        OP_SLL:  shifted = {in_dat[WIDTH-1-DIST:0], {DIST{1'b0}}};
        OP_ROR:  shifted = {in_dat[DIST-1:0], in_dat[WIDTH-1:DIST]};
        default: shifted = in_dat;
      endcase
    end
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    sha_d = sha_q;
    op_d  = op_q;
    sgn_d = sgn_q;
    tag_d = tag_q;
    if (adv) begin
      vld_d = in_vld;
      dat_d = shifted;
      sha_d = in_sha;
      op_d  = in_op;
      sgn_d = in_sgn;
      tag_d = in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      sha_q <= '0;
      op_q  <= OP_SRL;
      sgn_q <= 1'b0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      sha_q <= sha_d;
      op_q  <= op_d;
      sgn_q <= sgn_d;
      tag_q <= tag_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;
  assign out_sha = sha_q;
  assign out_op  = op_q;
  assign out_sgn = sgn_q;
  assign out_tag = tag_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// SRL/SRA/SLL/ROR barrel shifter, one register stage per sha bit; latency log2(WIDTH).
// Whole pipe advances together when output is empty or taken; in_ready mirrors that.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_sha,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             busy
);

  // Index 0 is the input port, index k+1 is the register output of stage k.
  logic             vld [SHW+1];
  logic [WIDTH-1:0] dat [SHW+1];
  logic [SHW-1:0]   sha [SHW+1];
  op_t              op  [SHW+1];
  logic             sgn [SHW+1];
  logic [TAG_W-1:0] tag [SHW+1];
  logic             adv;
  logic             unused_tail;

  assign adv    = out_ready | ~out_valid;
  assign vld[0] = in_valid;
  assign dat[0] = in_data;
  assign sha[0] = in_sha;
  assign op[0]  = op_t'(in_op);
  assign sgn[0] = in_data[WIDTH-1];
  assign tag[0] = in_tag;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .SHW   (SHW),
      .DIST  (1 << k)
    ) u_stage (
      .clk     (clk),
      .rst     (reset),
      .adv     (adv),
      .in_vld  (vld[k]),
      .in_dat  (dat[k]),
      .in_sha  (sha[k]),
      .in_op   (op[k]),
      .in_sgn  (sgn[k]),
      .in_tag  (tag[k]),
      .out_vld (vld[k+1]),
      .out_dat (dat[k+1]),
      .out_sha (sha[k+1]),
      .out_op  (op[k+1]),
      .out_sgn (sgn[k+1]),
      .out_tag (tag[k+1])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= SHW; k++) begin
      busy = busy | vld[k];
    end
  end

  assign in_ready    = adv;
  assign out_valid   = vld[SHW];
  assign out_data    = dat[SHW];
  assign out_tag     = tag[SHW];
  assign out_zero    = (dat[SHW] == '0);
  assign unused_tail = ^{sha[SHW], sgn[SHW], op[SHW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: queue-based reference model plus directed literals.
module tb_pipelined_barrel_shifter;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int SHW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SHW-1:0] in_sha;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_zero;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    int            age;
  } ent_t;
  ent_t q[$];

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sha    (in_sha),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_shift(logic [W-1:0] d, int s, logic [1:0] op);
    logic [2*W-1:0] dd;
    case (op)
      2'b00:   return d >> s;
      2'b01:   return $signed(d) >>> s;
      2'b10:   return d << s;
      default: begin
        dd = {d, d} >> s;
        return dd[W-1:0];
      end
    endcase
  endfunction

  function automatic bit m_vld();
    return (q.size() > 0) && (q[0].age == SHW);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted op ages by one per advancing edge, exits at age SHW.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
      end else begin
        bit adv;
        adv = out_ready || !m_vld();
        if (m_vld() && out_ready) void'(q.pop_front());
        if (adv) begin
          foreach (q[i]) q[i].age = q[i].age + 1;
          if (in_valid) q.push_back('{ref_shift(in_data, int'(in_sha), in_op), in_tag, 1});
        end
      end
    end
  end

  // Compare process.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_zero", out_zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
      end else begin
        bit ev;
        ev = m_vld();
        chk("out_valid", out_valid, ev);
        if (ev) begin
          chk("out_data", out_data, q[0].d);
          chk("out_tag", out_tag, q[0].t);
          chk("out_zero", out_zero, q[0].d == 0);
        end
        chk("busy", busy, q.size() != 0);
        chk("in_ready", in_ready, out_ready || !ev);
      end
    end
  end

  // Count output handshakes just before each active edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset && out_valid && out_ready) hs_count++;
    end
  end

  task automatic send(logic [W-1:0] d, logic [SHW-1:0] s, logic [1:0] op, logic [TW-1:0] t);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sha   = s;
    in_op    = op;
    in_tag   = t;
    acc = 0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      #4;
      acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic directed(string nm, logic [W-1:0] d, logic [SHW-1:0] s, logic [1:0] op,
                          logic [TW-1:0] t, logic [W-1:0] exp);
    int n;
    send(d, s, op, t);
    for (n = 1; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
    end
    chk({nm, "_latency"}, n, SHW);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_tag"}, out_tag, t);
    chk({nm, "_zero"}, out_zero, exp == 0);
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain_model_empty", q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    int hs0;
    logic [W-1:0]  fd;
    logic [TW-1:0] ft;
    bit rdone;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sha = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_zero", out_zero, 1);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;

    directed("sra", 32'h8000_0010, 5'd4, 2'b01, 4'd3, 32'hF800_0001);
    directed("ror", 32'h0000_0001, 5'd1, 2'b11, 4'd5, 32'h8000_0000);
    directed("sll", 32'h0000_0001, 5'd31, 2'b10, 4'd6, 32'h8000_0000);
    directed("srl", 32'h8000_0000, 5'd31, 2'b00, 4'd7, 32'h0000_0001);
    directed("zero", 32'h0000_000F, 5'd4, 2'b00, 4'd8, 32'h0000_0000);
    for (int m = 0; m < 4; m++)
      directed("sha0", 32'h8765_4321, 5'd0, 2'(m), 4'(m), 32'h8765_4321);

    // Back-pressure: eight back-to-back ops, output held for three cycles.
    hs0 = hs_count;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'hF0F0_0000 | 32'(i * 33), 5'(i + 1), 2'(i), 4'(i + 1));
      end
      begin
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 30) begin
          @(negedge clk);
          seen = out_valid;
          n++;
        end
        chk("bp_out_valid_seen", seen, 1);
        #1;
        out_ready = 1'b0;
        fd = out_data;
        ft = out_tag;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          @(negedge clk);
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_valid_held", out_valid, 1);
          chk("bp_data_held", out_data, fd);
          chk("bp_tag_held", out_tag, ft);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_result_count", hs_count - hs0, 8);

    // Randomized traffic with random downstream stalls.
    rdone = 0;
    hs0 = hs_count;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #2;
          end
          send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)));
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_result_count", hs_count - hs0, 300);

    // Reset with three operations in flight.
    send(32'h1234_5678, 5'd3, 2'b00, 4'd1);
    send(32'h8765_4321, 5'd7, 2'b01, 4'd2);
    send(32'hDEAD_BEEF, 5'd9, 2'b11, 4'd3);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    directed("post_rst", 32'h0000_00F0, 5'd4, 2'b00, 4'd9, 32'h0000_000F);
    repeat (10) @(posedge clk);
    #2;
    chk("post_rst_idle_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 SHALL derive localparam SHW = log2(WIDTH), the shift-amount width and the pipeline depth.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  an operation is presented on the input.
REQ-007 in_ready  output  1  the block accepts the input this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_sha  input  SHW  shift amount, 0..WIDTH-1.
REQ-010 in_op  input  2  mode: 00 SRL (logical right), 01 SRA (arithmetic right), 10 SLL (logical left), 11 ROR (rotate right).
REQ-011 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-012 out_valid  output  1  a result is presented on the output.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  WIDTH  shifted result.
REQ-015 out_tag  output  TAG_W  tag of the operation.
REQ-016 out_zero  output  1  out_data equals zero.
REQ-017 busy  output  1  at least one pipeline stage holds a valid operation.

Function
REQ-018 SHALL implement SHW register stages; stage k (k=0..SHW-1) shifts its operand by 2^k when sha bit k is 1, else passes it through.
REQ-019 SHALL register data, remaining sha bits, op, tag and a valid bit at each stage; latency from input acceptance to out_valid SHALL be exactly SHW cycles with no stall.
REQ-020 Fill rules: SRL and SLL SHALL fill with 0; SRA SHALL fill with the original operand MSB, carried with the operation; ROR SHALL wrap the bits shifted out back into the MSBs.
REQ-021 sha = 0 SHALL return in_data unchanged in every mode.
REQ-022 Global advance = out_ready OR NOT out_valid; when advance is 1, every stage SHALL load from its predecessor, and stage 0 SHALL load the input, with valid = in_valid.
REQ-023 in_ready SHALL equal advance and be combinational; a transfer occurs when in_valid AND in_ready.
REQ-024 When advance is 0, all stages SHALL hold data, tag and valid unchanged; bubbles do not collapse.
REQ-025 out_data, out_tag and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 out_zero SHALL be computed combinationally from the final-stage data.
REQ-027 busy SHALL be the OR of all stage valid bits.
REQ-028 Ordering SHALL be strictly FIFO; at most one result per cycle; full throughput of one operation per cycle with out_ready held at 1.

Reset
REQ-029 Asserting reset SHALL immediately clear all stage valid bits, data, sha, op and tag registers to 0; in-flight operations SHALL be discarded.
REQ-030 During reset: out_valid=0, out_data=0, out_tag=0, out_zero=1, busy=0, in_ready=1.
REQ-031 An input presented in the cycle reset deasserts SHALL be accepted normally at the next rising edge.

Structure
REQ-032 Package shifter_pkg SHALL hold the op encodings (OP_SRL, OP_SRA, OP_SLL, OP_ROR) and the 2-bit op type.
REQ-033 Sub-module shift_stage, parametrised by WIDTH, TAG_W and shift distance, SHALL implement one mux-plus-register stage; the top SHALL instantiate SHW of them via generate.

Verification (WIDTH=32, TAG_W=4, latency 5)
REQ-034 SRA: in_data=0x80000010, sha=4, op=01, tag=3 -> 5 cycles later out_data=0xF8000001, out_tag=3, out_zero=0.
REQ-035 ROR: in_data=0x00000001, sha=1, op=11 -> out_data=0x80000000; SLL: 0x00000001, sha=31 -> 0x80000000; SRL: 0x80000000, sha=31 -> 0x00000001.
REQ-036 Back-pressure: stream 8 operations back to back, hold out_ready=0 for 3 cycles once out_valid=1 -> in_ready=0 and all outputs frozen; after release, 8 results in order with no loss or duplication.
REQ-037 Zero: SRL 0x0000000F, sha=4 -> out_data=0, out_zero=1; sha=0 in all four modes -> operand unchanged.
REQ-038 Reset mid-flight: 3 operations in the pipe, assert reset -> out_valid=0 and busy=0 immediately, and no stale result appears after release.
